// File: rtl/ppu_pkg.sv
// Shared PPU timing constants and the STAT mode encoding used by the
// line/mode scheduler and its dot counter.
package ppu_pkg;

    typedef enum logic [1:0] {
        PPU_HBLANK = 2'd0,
        PPU_VBLANK = 2'd1,
        PPU_OAM    = 2'd2,
        PPU_XFER   = 2'd3
    } ppu_mode_t;

    localparam int DOTS_PER_LINE   = 456;
    localparam int VISIBLE_LINES   = 144;
    localparam int TOTAL_LINES     = 154;
    localparam int MODE2_DOTS      = 80;
    localparam int MODE3_MAX_DOTS  = 289;
    localparam int LY153_QUIRK_DOT = 4;

endpackage

// File: rtl/ppu_mode_scheduler_if.sv
// Start/done pulse pair between the mode scheduler and the OAM search /
// pixel transfer engines.
interface ppu_mode_scheduler_if;
    // Each start is a one-clk pulse launching its engine; the engine answers
    // with a one-clk done pulse. There is no back-pressure: a done pulse
    // outside the matching mode is dropped, and a late one is tolerated.
    logic mode2_start;
    logic mode2_done;
    logic mode3_start;
    logic mode3_done;

    modport master (output mode2_start, output mode3_start,
                    input  mode2_done,  input  mode3_done);
    modport slave  (input  mode2_start, input  mode3_start,
                    output mode2_done,  output mode3_done);
endinterface

// File: rtl/ppu_dot_counter.sv
// Dot-within-line and line counters; exposes next-state values and the
// line wrap strobe so the scheduler can react in the same clk.
module ppu_dot_counter
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       adv,
    output logic [8:0] dot,
    output logic [8:0] dot_nxt,
    output logic [7:0] ly_nxt,
    output logic       line_wrap
);

    localparam logic [8:0] LAST_DOT = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LAST_LY  = 8'(TOTAL_LINES - 1);

    logic [7:0] ly_q;

    always_comb begin
        line_wrap = adv && (dot == LAST_DOT);
        dot_nxt   = dot;
        ly_nxt    = ly_q;
        if (clear) begin
            dot_nxt = '0;
            ly_nxt  = '0;
        end else if (line_wrap) begin
            dot_nxt = '0;
            ly_nxt  = (ly_q == LAST_LY) ? 8'd0 : ly_q + 8'd1;
        end else if (adv) begin
            dot_nxt = dot + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dot  <= '0;
            ly_q <= '0;
        end else begin
            dot  <= dot_nxt;
            ly_q <= ly_nxt;
        end
    end

endmodule

// File: rtl/ppu_mode_scheduler.sv
// Per-dot PPU line/mode sequencer: STAT mode FSM, engine launch, LYC compare
// and STAT/VBlank interrupts. Optional macro PPU_LY153_QUIRK_EN.
module ppu_mode_scheduler
    import ppu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dot_en,
    input  logic                        lcd_en,
    input  logic [7:0]                  lyc,
    input  logic [3:0]                  stat_sel,
    ppu_mode_scheduler_if.master        eng,
    output logic [1:0]                  mode,
    output logic [7:0]                  ly,
    output logic [8:0]                  dot,
    output logic                        lyc_match,
    output logic                        stat_irq,
    output logic                        vblank_irq,
    output logic                        overrun
);

    localparam logic [1:0] S_HBLANK = PPU_HBLANK;
    localparam logic [1:0] S_VBLANK = PPU_VBLANK;
    localparam logic [1:0] S_OAM    = PPU_OAM;
    localparam logic [1:0] S_XFER   = PPU_XFER;
    localparam logic [8:0] XFER_DOT = 9'(MODE2_DOTS);
    localparam logic [8:0] END_DOT  = 9'(MODE2_DOTS + MODE3_MAX_DOTS);
    localparam logic [7:0] VIS_LY   = 8'(VISIBLE_LINES);

    logic       running, running_nxt;
    logic       m2_latch, latch_nxt;
    logic       stat_line, stat_line_nxt;
    logic [1:0] mode_nxt;
    logic       m2s_nxt, m3s_nxt, vb_nxt, ovr_nxt, lyc_match_nxt;
    logic [7:0] ly_nxt, ly_rep_nxt;
    logic [8:0] dot_nxt;
    logic       adv, line_wrap;

    assign adv = lcd_en && dot_en && running;

    ppu_dot_counter u_dot_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (!lcd_en),
        .adv       (adv),
        .dot       (dot),
        .dot_nxt   (dot_nxt),
        .ly_nxt    (ly_nxt),
        .line_wrap (line_wrap)
    );

    always_comb begin
        mode_nxt    = mode;
        running_nxt = running;
        latch_nxt   = m2_latch;
        m2s_nxt     = 1'b0;
        m3s_nxt     = 1'b0;
        vb_nxt      = 1'b0;
        ovr_nxt     = overrun;
        if (!lcd_en) begin
            mode_nxt    = S_HBLANK;
            running_nxt = 1'b0;
            latch_nxt   = 1'b0;
        end else if (!running) begin
            if (dot_en) begin
                running_nxt = 1'b1;
                mode_nxt    = S_OAM;
                m2s_nxt     = 1'b1;
                latch_nxt   = 1'b0;
            end
        end else if (line_wrap) begin
            // A done pulse coinciding with the wrap belongs to the old line.
            latch_nxt = 1'b0;
            if (ly_nxt < VIS_LY) begin
                mode_nxt = S_OAM;
                m2s_nxt  = 1'b1;
            end else if (ly_nxt == VIS_LY) begin
                mode_nxt = S_VBLANK;
                vb_nxt   = 1'b1;
            end
        end else begin
            case (mode)
                S_OAM: begin
                    if (eng.mode2_done) latch_nxt = 1'b1;
                    if (adv && dot_nxt == END_DOT) begin
                        mode_nxt = S_HBLANK;
                        ovr_nxt  = 1'b1;
                    end else if (m2_latch && dot_nxt >= XFER_DOT) begin
                        mode_nxt = S_XFER;
                        m3s_nxt  = 1'b1;
                    end else if (adv && dot_nxt == XFER_DOT) begin
                        ovr_nxt  = 1'b1;
                    end
                end
                S_XFER: begin
                    if (eng.mode3_done) begin
                        mode_nxt = S_HBLANK;
                    end else if (adv && dot_nxt == END_DOT) begin
                        mode_nxt = S_HBLANK;
                        ovr_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

`ifdef PPU_LY153_QUIRK_EN
        ly_rep_nxt = (ly_nxt == 8'(TOTAL_LINES - 1) && dot_nxt >= 9'(LY153_QUIRK_DOT))
                     ? 8'd0 : ly_nxt;
`else
        ly_rep_nxt = ly_nxt;
`endif
        lyc_match_nxt = lcd_en && (ly_rep_nxt == lyc);
        stat_line_nxt = running_nxt &&
                        ((stat_sel[0] && mode_nxt == S_HBLANK) ||
                         (stat_sel[1] && mode_nxt == S_VBLANK) ||
                         (stat_sel[2] && mode_nxt == S_OAM)    ||
                         (stat_sel[3] && lyc_match_nxt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode            <= S_HBLANK;
            running         <= 1'b0;
            m2_latch        <= 1'b0;
            stat_line       <= 1'b0;
            ly              <= '0;
            lyc_match       <= 1'b0;
            stat_irq        <= 1'b0;
            vblank_irq      <= 1'b0;
            overrun         <= 1'b0;
            eng.mode2_start <= 1'b0;
            eng.mode3_start <= 1'b0;
        end else begin
            mode            <= mode_nxt;
            running         <= running_nxt;
            m2_latch        <= latch_nxt;
            stat_line       <= stat_line_nxt;
            ly              <= ly_rep_nxt;
            lyc_match       <= lyc_match_nxt;
            stat_irq        <= stat_line_nxt && !stat_line;
            vblank_irq      <= vb_nxt;
            overrun         <= ovr_nxt;
            eng.mode2_start <= m2s_nxt;
            eng.mode3_start <= m3s_nxt;
        end
    end

endmodule
